dump_window_ctl: RTL and testbench

Parametrised frame-window trigger for simulation and debug capture. It counts frames from the video vertical sync and arms on one of three selectable conditions. It then drives CH independent dump-enable windows, each a start offset plus a length in frames, and queues frame-stamped start/stop events in a small FIFO for a logger or a UART trace port. It sits beside the game top level in the test harness and replaces ad hoc per-core dump triggers.

---
 rtl/dump_window_ctl.sv | 247 ++++++++++++++++++++++++
 tb/tb_dump_window_ctl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_window_ctl.sv
// dump_window_ctl: frame-window trigger for simulation/debug capture.
// Counts frames on vs falling edges, arms once on a MODE-selected condition,
// then runs CH independent dump windows (start offset + length in frames)
// and queues frame-stamped start/stop events in a first-word fall-through FIFO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   vs                  vertical sync (frame boundary = falling edge)
//   dwnld               ROM download active (falling edge = download end)
//   ch_en[CH]           per-channel enable, sampled at arm; low while ON stops it
//   win_start[16*CH]    per-channel start offset in frames after arm
//   win_len[16*CH]      per-channel window length in frames (0 = unlimited)
//   frame_cnt[FW]       frames seen since reset (saturating)
//   armed               arm condition has occurred
//   dump_on[CH]         per-channel window active
//   ev_valid/ev_ready   event FIFO head handshake
//   ev_stop/ev_ch/ev_frame  head event: stop flag, channel, frame stamp
module dump_window_ctl #(
  parameter int unsigned CH     = 4,
  parameter int unsigned FW     = 32,
  parameter int unsigned MODE   = 0,
  parameter int unsigned START  = 0,
  parameter logic [15:0] MINCYC = 16'd20000,
  parameter int unsigned DEPTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             dwnld,
  input  logic [CH-1:0]    ch_en,
  input  logic [16*CH-1:0] win_start,
  input  logic [16*CH-1:0] win_len,
  output logic [FW-1:0]    frame_cnt,
  output logic             armed,
  output logic [CH-1:0]    dump_on,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_stop,
  output logic [2:0]       ev_ch,
  output logic [FW-1:0]    ev_frame
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = FW + 4;
  localparam logic [FW-1:0] START_F   = FW'(START);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ON, S_DONE} state_t;

  logic          r_vs_l, r_dw_l;
  logic          w_vs_fall, w_dw_fall;
  logic [FW-1:0] r_frame_cnt, w_frame_nxt;
  logic [15:0]   r_cyc_cnt;
  logic [15:0]   r_rel_cnt;
  logic          r_armed, w_arm_cond, w_arm;

  state_t        r_state       [CH];
  logic [15:0]   r_on_cnt      [CH];
  logic [FW-1:0] r_start_frame [CH];
  logic [FW-1:0] r_stop_frame  [CH];
  logic [CH-1:0] r_start_pend, r_stop_pend;
  logic [15:0]   w_win_start   [CH];
  logic [15:0]   w_win_len     [CH];

  logic          w_sel_vld, w_sel_stop, w_room, w_grant;
  logic [2:0]    w_sel_ch;
  logic [FW-1:0] w_sel_frame;
  logic [CW:0]   w_occ;

  logic          r_push, r_push_stop;
  logic [2:0]    r_push_ch;
  logic [FW-1:0] r_push_frame;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_wr, w_full;
  logic [EW-1:0] w_head;

  // Edge detection and saturating next frame value
  assign w_vs_fall   = r_vs_l & ~vs;
  assign w_dw_fall   = r_dw_l & ~dwnld;
  assign w_frame_nxt = (w_vs_fall && (r_frame_cnt != '1)) ? r_frame_cnt + FW'(1) : r_frame_cnt;

  // Arm condition; one-shot via r_armed
  always_comb begin
    w_arm_cond = 1'b0;
    if (MODE == 0)      w_arm_cond = 1'b1;
    else if (MODE == 1) w_arm_cond = w_dw_fall && (r_cyc_cnt >= MINCYC);
    else if (MODE == 2) w_arm_cond = w_vs_fall && (r_frame_cnt == START_F);
    w_arm = w_arm_cond & ~r_armed;
  end

  // Frame, cycle and post-arm counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_l      <= 1'b0;
      r_dw_l      <= 1'b0;
      r_frame_cnt <= '0;
      r_cyc_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_vs_l      <= vs;
      r_dw_l      <= dwnld;
      r_frame_cnt <= w_frame_nxt;
      if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 16'd1;
      if (w_arm) begin
        r_armed   <= 1'b1;
        r_rel_cnt <= '0;
      end else if (r_armed && w_vs_fall && (r_rel_cnt != '1)) begin
        r_rel_cnt <= r_rel_cnt + 16'd1;
      end
    end
  end

  // Per-channel window slices
  always_comb begin
    for (int i = 0; i < int'(CH); i++) begin
      w_win_start[i] = win_start[16*i +: 16];
      w_win_len[i]   = win_len[16*i +: 16];
    end
  end

  // Per-channel window FSMs and pending event flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CH); i++) begin
        r_state[i]       <= S_IDLE;
        r_on_cnt[i]      <= '0;
        r_start_frame[i] <= '0;
        r_stop_frame[i]  <= '0;
      end
      r_start_pend <= '0;
      r_stop_pend  <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        if (w_grant && (w_sel_ch == 3'(i))) begin
          if (w_sel_stop) r_stop_pend[i]  <= 1'b0;
          else            r_start_pend[i] <= 1'b0;
        end
        case (r_state[i])
          S_IDLE: begin
            if (w_arm) r_state[i] <= ch_en[i] ? S_WAIT : S_DONE;
          end
          S_WAIT: begin
            if ((w_win_start[i] == 16'd0) ||
                (w_vs_fall && ((r_rel_cnt + 16'd1) == w_win_start[i]))) begin
              r_state[i]       <= S_ON;
              r_on_cnt[i]      <= '0;
              r_start_pend[i]  <= 1'b1;
              r_start_frame[i] <= w_frame_nxt;
            end
          end
          S_ON: begin
            // Losing the enable ends the window at once; otherwise the
            // closing frame boundary is the win_len-th since entry.
            if (!ch_en[i] ||
                (w_vs_fall && (w_win_len[i] != 16'd0) &&
                 ((r_on_cnt[i] + 16'd1) == w_win_len[i]))) begin
              r_state[i]      <= S_DONE;
              r_stop_pend[i]  <= 1'b1;
              r_stop_frame[i] <= w_frame_nxt;
            end else if (w_vs_fall && (r_on_cnt[i] != '1)) begin
              r_on_cnt[i] <= r_on_cnt[i] + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dump_on = '0;
    for (int i = 0; i < int'(CH); i++) dump_on[i] = (r_state[i] == S_ON);
  end

  // Arbiter: lowest channel wins, start before stop within a channel.
  // Room accounts for the event already held in the push stage.
  always_comb begin
    w_sel_vld   = 1'b0;
    w_sel_stop  = 1'b0;
    w_sel_ch    = '0;
    w_sel_frame = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (r_start_pend[i] || r_stop_pend[i]) begin
        w_sel_vld   = 1'b1;
        w_sel_ch    = 3'(i);
        w_sel_stop  = ~r_start_pend[i];
        w_sel_frame = r_start_pend[i] ? r_start_frame[i] : r_stop_frame[i];
      end
    end
    w_occ   = {1'b0, r_count} + (CW + 1)'(r_push);
    w_room  = (w_occ < OCC_LIMIT);
    w_grant = w_sel_vld & w_room;
  end

  // Push stage between arbiter and FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push       <= 1'b0;
      r_push_stop  <= 1'b0;
      r_push_ch    <= '0;
      r_push_frame <= '0;
    end else begin
      r_push <= w_grant;
      if (w_grant) begin
        r_push_stop  <= w_sel_stop;
        r_push_ch    <= w_sel_ch;
        r_push_frame <= w_sel_frame;
      end
    end
  end

  // Event FIFO, first-word fall-through
  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = (r_count != '0) & ev_ready;
  assign w_wr   = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_push_stop, r_push_ch, r_push_frame};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign frame_cnt = r_frame_cnt;
  assign armed     = r_armed;
  assign ev_valid  = (r_count != '0);
  assign ev_stop   = ev_valid & w_head[EW-1];
  assign ev_ch     = ev_valid ? w_head[EW-2 -: 3] : 3'd0;
  assign ev_frame  = ev_valid ? w_head[FW-1:0] : '0;

endmodule

// File: tb/tb_dump_window_ctl.sv
// Testbench for dump_window_ctl: three instances (MODE 0/1/2), scoreboard on
// the MODE 0 event stream, direct checks on counters and window outputs.
module tb_dump_window_ctl;

  localparam int unsigned CH = 4;
  localparam int unsigned FW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MODE 0 instance
  logic          m0_rst = 1'b1, m0_vs = 1'b0, m0_dw = 1'b0, m0_rdy = 1'b1;
  logic [CH-1:0] m0_en = '0;
  logic [63:0]   m0_ws = '0, m0_wl = '0;
  logic [FW-1:0] m0_frame, m0_evf;
  logic          m0_armed, m0_valid, m0_stop;
  logic [CH-1:0] m0_dump;
  logic [2:0]    m0_ch;

  // MODE 1 instance
  logic          m1_rst = 1'b1, m1_vs = 1'b0, m1_dw = 1'b1;
  logic [FW-1:0] m1_frame, m1_evf;
  logic          m1_armed, m1_valid, m1_stop;
  logic [CH-1:0] m1_dump;
  logic [2:0]    m1_ch;

  // MODE 2 instance
  logic          m2_rst = 1'b1, m2_vs = 1'b0;
  logic [CH-1:0] m2_en = '0;
  logic [FW-1:0] m2_frame, m2_evf;
  logic          m2_armed, m2_valid, m2_stop;
  logic [CH-1:0] m2_dump;
  logic [2:0]    m2_ch;

  dump_window_ctl #(.CH(CH), .FW(FW), .MODE(0), .DEPTH(8)) u_m0 (
    .clk(clk), .rst(m0_rst), .vs(m0_vs), .dwnld(m0_dw), .ch_en(m0_en),
    .win_start(m0_ws), .win_len(m0_wl), .frame_cnt(m0_frame), .armed(m0_armed),
    .dump_on(m0_dump), .ev_valid(m0_valid), .ev_ready(m0_rdy), .ev_stop(m0_stop),
    .ev_ch(m0_ch), .ev_frame(m0_evf));

  dump_window_ctl #(.CH(CH), .FW(FW), .MODE(1), .MINCYC(16'd20000), .DEPTH(8)) u_m1 (
    .clk(clk), .rst(m1_rst), .vs(m1_vs), .dwnld(m1_dw), .ch_en(4'b0000),
    .win_start(64'd0), .win_len(64'd0), .frame_cnt(m1_frame), .armed(m1_armed),
    .dump_on(m1_dump), .ev_valid(m1_valid), .ev_ready(1'b1), .ev_stop(m1_stop),
    .ev_ch(m1_ch), .ev_frame(m1_evf));

  dump_window_ctl #(.CH(CH), .FW(FW), .MODE(2), .START(5), .DEPTH(8)) u_m2 (
    .clk(clk), .rst(m2_rst), .vs(m2_vs), .dwnld(1'b0), .ch_en(m2_en),
    .win_start(64'd0), .win_len(64'd0), .frame_cnt(m2_frame), .armed(m2_armed),
    .dump_on(m2_dump), .ev_valid(m2_valid), .ev_ready(1'b1), .ev_stop(m2_stop),
    .ev_ch(m2_ch), .ev_frame(m2_evf));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_f0   = 0;

  logic [35:0] sb_q[$];
  logic [35:0] sb_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk_ev(input bit stop, input int ch, input int fr);
    return {stop, 3'(ch), 32'(fr)};
  endfunction

  // Scoreboard: compare every accepted head against the oldest expectation
  always @(negedge clk) begin
    if (!m0_rst && m0_valid && m0_rdy) begin
      check_val("sb_avail", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check_val("ev", {28'd0, m0_stop, m0_ch, m0_evf}, {28'd0, sb_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse0();
    m0_vs = 1'b1;
    tick_n(2);
    m0_vs = 1'b0;
    tick_n(4);
    exp_f0++;
  endtask

  task automatic pulse2();
    m2_vs = 1'b1;
    tick_n(2);
    m2_vs = 1'b0;
    tick_n(4);
  endtask

  task automatic reset0();
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    m0_rst = 1'b1;
    tick_n(2);
    exp_f0 = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tick_n(2);

    // A: two windows, offsets {0,3}, lengths {2,1}
    m0_en = 4'b0011;
    m0_ws = {16'd0, 16'd0, 16'd3, 16'd0};
    m0_wl = {16'd0, 16'd0, 16'd1, 16'd2};
    reset0();
    check_val("rst_frame", 64'(m0_frame), 64'd0);
    check_val("rst_armed", 64'(m0_armed), 64'd0);
    check_val("rst_dump", 64'(m0_dump), 64'd0);
    check_val("rst_evvld", 64'(m0_valid), 64'd0);
    check_val("rst_evhead", {28'd0, m0_stop, m0_ch, m0_evf}, 64'd0);
    sb_q.push_back(mk_ev(0, 0, 0));
    sb_q.push_back(mk_ev(1, 0, 2));
    sb_q.push_back(mk_ev(0, 1, 3));
    sb_q.push_back(mk_ev(1, 1, 4));
    m0_rst = 1'b0;
    check_val("m0_armed_pre", 64'(m0_armed), 64'd0);
    tick();
    check_val("m0_armed", 64'(m0_armed), 64'd1);
    check_val("m0_dump_wait", 64'(m0_dump), 64'd0);
    tick();
    check_val("m0_dump_on0", 64'(m0_dump), 64'd1);
    for (int k = 1; k <= 10; k++) begin
      pulse0();
      check_val("a_frame", 64'(m0_frame), 64'(k));
      check_val("a_dump", 64'(m0_dump), {62'd0, (k == 3), (k < 2)});
    end
    tick_n(10);

    // B: enable dropped while ON
    m0_en = 4'b0001;
    m0_ws = '0;
    m0_wl = '0;
    reset0();
    sb_q.push_back(mk_ev(0, 0, 0));
    m0_rst = 1'b0;
    tick_n(2);
    check_val("b_dump_on", 64'(m0_dump), 64'd1);
    for (int k = 0; k < 3; k++) pulse0();
    tick_n(2);
    m0_en = 4'b0000;
    tick();
    check_val("b_dump_off", 64'(m0_dump), 64'd0);
    sb_q.push_back(mk_ev(1, 0, exp_f0));
    tick_n(8);

    // C: back-pressure, 4 channels x start/stop = 8 queued events
    m0_en  = 4'b1111;
    m0_wl  = {4{16'd1}};
    m0_rdy = 1'b0;
    reset0();
    m0_rst = 1'b0;
    tick_n(2);
    check_val("c_dump_all", 64'(m0_dump), 64'hf);
    for (int c = 0; c < 4; c++) sb_q.push_back(mk_ev(0, c, 0));
    tick_n(8);
    pulse0();
    check_val("c_dump_done", 64'(m0_dump), 64'd0);
    for (int c = 0; c < 4; c++) sb_q.push_back(mk_ev(1, c, exp_f0));
    tick_n(10);
    check_val("c_held_vld", 64'(m0_valid), 64'd1);
    check_val("c_held_head", {60'd0, m0_stop, m0_ch}, 64'd0);
    check_val("c_pending", 64'(sb_q.size()), 64'd8);
    m0_rdy = 1'b1;
    tick_n(20);
    check_val("c_drained", 64'(sb_q.size()), 64'd0);
    check_val("c_empty", 64'(m0_valid), 64'd0);

    // D: reset mid-window with an event still queued
    m0_en  = 4'b0001;
    m0_wl  = '0;
    m0_rdy = 1'b0;
    reset0();
    m0_rst = 1'b0;
    tick_n(2);
    pulse0();
    pulse0();
    check_val("d_dump", 64'(m0_dump), 64'd1);
    check_val("d_frame", 64'(m0_frame), 64'd2);
    check_val("d_vld", 64'(m0_valid), 64'd1);
    m0_rst = 1'b1;
    m0_en  = 4'b0000;
    tick();
    check_val("d_rst_frame", 64'(m0_frame), 64'd0);
    check_val("d_rst_armed", 64'(m0_armed), 64'd0);
    check_val("d_rst_dump", 64'(m0_dump), 64'd0);
    check_val("d_rst_vld", 64'(m0_valid), 64'd0);
    check_val("d_rst_head", {28'd0, m0_stop, m0_ch, m0_evf}, 64'd0);
    m0_rdy = 1'b1;
    m0_rst = 1'b0;
    tick_n(5);
    check_val("d_flushed", 64'(m0_valid), 64'd0);

    // E: MODE 2, START=5, unlimited window
    m2_en  = 4'b0001;
    tick_n(2);
    m2_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse2();
      check_val("e_not_armed", 64'(m2_armed), 64'd0);
    end
    m2_vs = 1'b1;
    tick_n(2);
    m2_vs = 1'b0;
    check_val("e_armed_pre", 64'(m2_armed), 64'd0);
    tick();
    check_val("e_armed", 64'(m2_armed), 64'd1);
    check_val("e_frame6", 64'(m2_frame), 64'd6);
    tick();
    check_val("e_dump_on", 64'(m2_dump), 64'd1);
    for (int k = 0; k < 20; k++) begin
      pulse2();
      check_val("e_dump_hold", 64'(m2_dump), 64'd1);
    end
    check_val("e_frame26", 64'(m2_frame), 64'd26);

    // F: MODE 1, early download end ignored, late one arms
    m1_rst = 1'b0;
    tick_n(100);
    m1_dw = 1'b0;
    tick_n(5);
    check_val("f_early", 64'(m1_armed), 64'd0);
    m1_dw = 1'b1;
    tick_n(29895);
    m1_dw = 1'b0;
    check_val("f_pre", 64'(m1_armed), 64'd0);
    tick();
    check_val("f_armed", 64'(m1_armed), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
